// File: rtl/bin_display_ctrl_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD display controller.
package bin_display_ctrl_pkg;

  localparam int unsigned IN_W       = 12;
  localparam int unsigned DIGITS     = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned CONV_ITERS = 12;

  localparam int unsigned ACC_W  = DIGITS * BCD_W;
  localparam int unsigned ITER_W = $clog2(CONV_ITERS + 1);
  localparam int unsigned IDX_W  = $clog2(DIGITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift {acc, sr} left by one.
module bcd_dabble_step
  import bin_display_ctrl_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W-1:0]  sr_i,
  output logic [ACC_W-1:0] acc_o,
  output logic [IN_W-1:0]  sr_o
);

  logic [ACC_W-1:0]      adj;
  logic [ACC_W+IN_W-1:0] shifted;

  always_comb begin
    adj = acc_i;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_i[k*BCD_W +: BCD_W] >= BCD_W'(5)) begin
        adj[k*BCD_W +: BCD_W] = acc_i[k*BCD_W +: BCD_W] + BCD_W'(3);
      end
    end
    shifted = {adj, sr_i} << 1;
  end

  assign acc_o = shifted[ACC_W+IN_W-1:IN_W];
  assign sr_o  = shifted[IN_W-1:0];

endmodule

// File: rtl/bin_display_ctrl.sv
// 12-bit binary to 4-digit BCD converter with a multiplexed, leading-zero-blanked display scan.
module bin_display_ctrl
  import bin_display_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic [IN_W-1:0]   VALUE_i,
  input  logic              LOAD_i,
  output logic              READY_o,
  output logic              DONE_o,
  output logic [ACC_W-1:0]  BCD_o,
  output logic [BCD_W-1:0]  DIG_o,
  output logic [DIGITS-1:0] AN_o
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);

  state_e            state_q, state_d;
  logic [IN_W-1:0]   sr_q, sr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ACC_W-1:0]  bcd_q, bcd_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [BCD_W-1:0]  dig_q, dig_d;

  logic [ACC_W-1:0]  step_acc;
  logic [IN_W-1:0]   step_sr;
  logic              pre_wrap;
  logic              upper_zero;

  bcd_dabble_step u_step (
    .acc_i (acc_q),
    .sr_i  (sr_q),
    .acc_o (step_acc),
    .sr_o  (step_sr)
  );

  // Conversion FSM next state; the result is latched on the last iteration edge.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (LOAD_i) begin
          sr_d    = VALUE_i;
          acc_d   = '0;
          iter_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d   = step_sr;
        acc_d  = step_acc;
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(CONV_ITERS - 1)) begin
          bcd_d   = step_acc;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // Free-running scan prescaler and digit index.
  always_comb begin
    pre_wrap = (pre_q == PRE_W'(SCAN_DIV - 1));
    pre_d    = pre_wrap ? '0 : pre_q + PRE_W'(1);
    idx_d    = pre_wrap ? idx_q + IDX_W'(1) : idx_q;
  end

  // Display outputs are computed from next-state values so they register in step with idx/bcd.
  always_comb begin
    dig_d      = bcd_d[int'(idx_d)*BCD_W +: BCD_W];
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((k >= int'(idx_d)) && (bcd_d[k*BCD_W +: BCD_W] != '0)) begin
        upper_zero = 1'b0;
      end
    end
    an_d = DIGITS'(1) << idx_d;
    if (BLANK_LZ && (idx_d != '0) && upper_zero) begin
      an_d = '0;
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      an_q    <= DIGITS'(1);
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      dig_q   <= dig_d;
    end
  end

  assign READY_o = ready_q;
  assign DONE_o  = done_q;
  assign BCD_o   = bcd_q;
  assign DIG_o   = dig_q;
  assign AN_o    = an_q;

endmodule

// File: tb/tb_bin_display_ctrl.sv
// Self-checking bench for bin_display_ctrl: decimal-arithmetic reference model, random and exhaustive stimulus.
module tb_bin_display_ctrl;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        RST_i = 1'b1;
  logic        LOAD_i = 1'b0;
  logic [11:0] VALUE_i = '0;

  logic        ready, done, ready_nb, done_nb;
  logic [15:0] bcd, bcd_nb;
  logic [3:0]  dig, an, dig_nb, an_nb;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_val = 0;
  int n_since_rst = 0;

  always #5 clk = ~clk;

  bin_display_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
    .CLK_i(clk), .RST_i(RST_i), .VALUE_i(VALUE_i), .LOAD_i(LOAD_i),
    .READY_o(ready), .DONE_o(done), .BCD_o(bcd), .DIG_o(dig), .AN_o(an)
  );

  bin_display_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_nb (
    .CLK_i(clk), .RST_i(RST_i), .VALUE_i(VALUE_i), .LOAD_i(LOAD_i),
    .READY_o(ready_nb), .DONE_o(done_nb), .BCD_o(bcd_nb), .DIG_o(dig_nb), .AN_o(an_nb)
  );

  // Edges since the last reset edge; the scan slot follows from this count alone.
  always @(posedge clk) begin
    if (RST_i) n_since_rst <= 0;
    else       n_since_rst <= n_since_rst + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic check_disp();
    int idx, p10, exp_an;
    idx = (n_since_rst / SCAN_DIV) % 4;
    p10 = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
    exp_an = ((idx > 0) && (exp_val < p10)) ? 0 : (1 << idx);
    check("dig", 32'(dig), 32'((exp_val / p10) % 10));
    check("an", 32'(an), 32'(exp_an));
    check("dig_nb", 32'(dig_nb), 32'((exp_val / p10) % 10));
    check("an_nb", 32'(an_nb), 32'(1 << idx));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_done", 32'(done), 32'd0);
      check("idle_bcd", 32'(bcd), 32'(bcd_of(exp_val)));
      check_disp();
    end
  endtask

  // k counts edges after the accepting edge: result and DONE at k=12, READY back at k=13.
  task automatic convert(input int val, input int reload_at, input int rst_at);
    @(negedge clk);
    check("pre_ready", 32'(ready), 32'd1);
    VALUE_i = 12'(val);
    LOAD_i  = 1'b1;
    @(posedge clk); #1;
    LOAD_i  = 1'b0;
    VALUE_i = 12'($urandom);
    for (int k = 1; k <= 13; k++) begin
      if (k == reload_at) begin
        LOAD_i  = 1'b1;
        VALUE_i = 12'd99;
      end
      if (k == rst_at) begin
        RST_i  = 1'b1;
        LOAD_i = 1'b1;
      end
      @(posedge clk); #1;
      LOAD_i = 1'b0;
      if (k == rst_at) begin
        RST_i   = 1'b0;
        exp_val = 0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h0000);
        check("rst_an", 32'(an), 32'b0001);
        check_disp();
        idle(16);
        return;
      end
      if (k == 12) exp_val = val;
      check("conv_done", 32'(done), 32'(k == 12));
      check("conv_ready", 32'(ready), 32'(k == 13));
      check("conv_bcd", 32'(bcd), 32'(bcd_of(exp_val)));
      check_disp();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd), 32'h0000);
    check("reset_an", 32'(an), 32'b0001);
    check("reset_dig", 32'(dig), 32'd0);
    RST_i = 1'b0;
    idle(5);

    convert(4095, 0, 0);
    check("bcd_4095", 32'(bcd), 32'h4095);
    idle(3);
    convert(0, 0, 0);
    idle(18);
    convert(1234, 0, 0);
    idle(20);
    convert(1234, 5, 0);
    check("bcd_reload", 32'(bcd), 32'h1234);
    convert(99, 0, 0);
    check("bcd_99", 32'(bcd), 32'h0099);
    idle(17);
    convert(777, 0, 6);
    convert(7, 0, 0);
    idle(17);

    for (int i = 0; i < 80; i++) begin
      int v, rl, rs;
      v  = int'($urandom_range(0, 4095));
      rl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 13)) : 0;
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 13)) : 0;
      convert(v, rl, rs);
      idle(int'($urandom_range(0, 6)));
    end

    for (int v = 0; v < 4096; v++) convert(v, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
